adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares one 6-bit ripple-carry adder (an internal `binary_adder` instance) between two independent requesters. Each requester presents operands under a level request. The block grants the adder round-robin, latches the granted operands, captures the 6-bit sum and returns it with a one-cycle done pulse. It sits between the two arithmetic clients and the single adder instance, so the adder itself needs no changes.

## Interface
- WIDTH, 6, operand/sum width. Only 6 is supported, to match the internal adder.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0  in  1  requester 0 asks for an add; a level signal.
- a0, b0  in  6 each  requester 0 operands; sampled only on the grant edge.
- gnt0  out  1  requester 0 owns the adder (GRANT and DONE states).
- done0  out  1  one-cycle pulse; sum0 is valid.
- sum0  out  6  result for requester 0; holds until requester 0's next completion.
- req1, a1, b1, gnt1, done1, sum1: same as above, for requester 1.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, GRANT and DONE. The owner register is 1 bit; the last-served pointer `last` is 1 bit.
- In IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that requester.
  - Both requests: grant the requester that is not `last`.
  - When granting: latch that requester's a/b into op_a/op_b, set owner, set `last` = owner, assert gnt of the owner, and go to GRANT.
- In GRANT: the adder inputs come from op_a/op_b. The adder output is captured into the owner's sum register. Go to DONE.
- In DONE: pulse the owner's done, keep the owner's gnt high, then go to IDLE unconditionally. req lines are not sampled in DONE.
- Arithmetic: sum = (op_a + op_b) mod 64. The carry is discarded and there is no overflow flag.
- Requester handshake:
  - The requester holds req high until it sees done.
  - It deasserts req at the clock edge that ends the done cycle.
  - A req still high in the following IDLE cycle counts as a new request.
  - a/b may change freely after the grant edge.
- The sum of the non-owner is never modified.
- Reset (asynchronous, any state):
  - State goes to IDLE and `last` = 1, so req0 wins the first tie.
  - op_a, op_b, sum0, sum1 = 0.
  - gnt0, gnt1, done0, done1, busy = 0.
  - An operation in flight is dropped and no done is issued for it.

## Timing
- Latency: req is sampled at edge E0 in IDLE. gnt and busy go high after E0. done and sum are valid after E0+1, for one cycle. The block is back in IDLE after E0+2.
- Minimum spacing between grants is 3 cycles. Throughput is one add per 3 cycles.
- With both requesters held continuously, completions alternate 0, 1, 0, 1, and the dones are 3 cycles apart.
- gnt of the owner is high for exactly 2 cycles per operation. gnt0 and gnt1 are never high together.
- done0 and done1 are never high together.
- sum0/sum1 change only in the cycle their own done rises.
- All outputs are registered. There is no combinational path from req or a/b to any output.

## Test plan
- **Single add:** after reset, req0=1, a0=5, b0=7 for one sample edge -> gnt0 high for 2 cycles, done0 pulses 2 cycles after the sample, sum0=12, sum1 stays 0.
- **Wrap-around:** req1, a1=40, b1=30 -> sum1=6. Also check a1=63, b1=1 -> sum1=0.
- **Tie after reset:** req0 (1+2) and req1 (10+20) raised on the same edge -> done0 with sum0=3 first, then done1 with sum1=30 three cycles later.
- **Fairness:** both reqs held high for 12 cycles -> completion order is 0, 1, 0, 1, and no done cycles overlap.
- **Operand isolation:** change a0 from 5 to 9 in the cycle after gnt0 rises -> sum0 is still 12.
- **Reset mid-operation:** pull rst_n low while in GRANT -> all outputs drop to 0 immediately and no done follows. Release rst_n with req0 still high -> a fresh grant occurs and the add completes normally.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 6-bit ripple-carry adder between two requesters.
// Operands are latched on the grant edge; the sum is returned with a one-cycle done pulse.

module binary_adder #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  logic carry;

  // The final carry is dropped, so the result wraps modulo 2**WIDTH.
  always_comb begin
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// state | meaning
// IDLE  | no owner; arbitrate between req0/req1 on each edge
// GRANT | owner's operands drive the adder; sum captured on exit
// DONE  | owner's done pulses; back to IDLE without sampling req
module adder_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  output logic             done0,
  output logic [WIDTH-1:0] sum0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic             done1,
  output logic [WIDTH-1:0] sum1,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             owner;
  logic             last;
  logic             pick;
  logic             any_req;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum0_q;
  logic [WIDTH-1:0] sum1_q;
  logic [WIDTH-1:0] add_sum;

  binary_adder #(.WIDTH(WIDTH)) u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum)
  );

  // On a tie the requester that was not served last wins.
  always_comb begin
    any_req = req0 | req1;
    pick    = (req0 && req1) ? ~last : req1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_GRANT;
      S_GRANT: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner  <= 1'b0;
      last   <= 1'b1;
      op_a   <= '0;
      op_b   <= '0;
      sum0_q <= '0;
      sum1_q <= '0;
    end else begin
      if (state == S_IDLE && any_req) begin
        owner <= pick;
        last  <= pick;
        op_a  <= pick ? a1 : a0;
        op_b  <= pick ? b1 : b0;
      end
      if (state == S_GRANT) begin
        if (owner) sum1_q <= add_sum;
        else       sum0_q <= add_sum;
      end
    end
  end

  // Outputs decode registered state only; nothing combinational from req or operands.
  always_comb begin
    busy  = (state != S_IDLE);
    gnt0  = busy && !owner;
    gnt1  = busy && owner;
    done0 = (state == S_DONE) && !owner;
    done1 = (state == S_DONE) && owner;
    sum0  = sum0_q;
    sum1  = sum1_q;
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter; expected results are queued at stimulus time
// and compared when a done pulse appears.

module tb_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [5:0] a0 = '0;
  logic [5:0] b0 = '0;
  logic [5:0] a1 = '0;
  logic [5:0] b1 = '0;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [5:0] sum0, sum1;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];
  logic [6:0] mon_e;

  adder_arbiter #(.WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .a0    (a0),
    .b0    (b0),
    .gnt0  (gnt0),
    .done0 (done0),
    .sum0  (sum0),
    .req1  (req1),
    .a1    (a1),
    .b1    (b1),
    .gnt1  (gnt1),
    .done1 (done1),
    .sum1  (sum1),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every done pops the oldest expected {id, sum}.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt_excl", {7'b0, gnt0 & gnt1}, 8'd0);
      chk("done_excl", {7'b0, done0 & done1}, 8'd0);
      if (done0 || done1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {1'b0, done1, (done1 ? sum1 : sum0)}, 8'h80);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_result", {1'b0, done1, (done1 ? sum1 : sum0)}, {1'b0, mon_e});
        end
      end
    end
  end

  task automatic run_one(input logic id, input logic [5:0] a, input logic [5:0] b,
                         input logic [5:0] exp_sum);
    exp_q.push_back({id, exp_sum});
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; end
    step();
    chk("op_gnt", {6'b0, gnt1, gnt0}, id ? 8'd2 : 8'd1);
    chk("op_busy", {7'b0, busy}, 8'd1);
    chk("op_no_early_done", {6'b0, done1, done0}, 8'd0);
    // Operands are free to move once the grant edge has passed.
    if (id) begin a1 = a1 + 6'd4; b1 = b1 + 6'd9; end
    else    begin a0 = a0 + 6'd4; b0 = b0 + 6'd9; end
    step();
    chk("op_done", {6'b0, done1, done0}, id ? 8'd2 : 8'd1);
    chk("op_gnt_hold", {6'b0, gnt1, gnt0}, id ? 8'd2 : 8'd1);
    chk("op_sum", {2'b0, (id ? sum1 : sum0)}, {2'b0, exp_sum});
    step();
    chk("op_idle", {5'b0, busy, gnt1, gnt0}, 8'd0);
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_flags", {3'b0, gnt0, gnt1, done0, done1, busy}, 8'd0);
    chk("rst_sum0", {2'b0, sum0}, 8'd0);
    chk("rst_sum1", {2'b0, sum1}, 8'd0);
    rst_n = 1'b1;
    step();

    run_one(1'b0, 6'd5, 6'd7, 6'd12);
    chk("single_sum1_untouched", {2'b0, sum1}, 8'd0);
    run_one(1'b1, 6'd40, 6'd30, 6'd6);
    run_one(1'b1, 6'd63, 6'd1, 6'd0);
    chk("wrap_sum0_untouched", {2'b0, sum0}, 8'd12);

    // Fresh reset so req0 must win the tie.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 6'd3});
    exp_q.push_back({1'b1, 6'd30});
    req0 = 1'b1; a0 = 6'd1;  b0 = 6'd2;
    req1 = 1'b1; a1 = 6'd10; b1 = 6'd20;
    step();
    chk("tie_first_gnt", {6'b0, gnt1, gnt0}, 8'd1);
    step();
    chk("tie_done0", {6'b0, done1, done0}, 8'd1);
    chk("tie_sum0", {2'b0, sum0}, 8'd3);
    step();
    req0 = 1'b0;
    step();
    chk("tie_second_gnt", {6'b0, gnt1, gnt0}, 8'd2);
    step();
    chk("tie_done1", {6'b0, done1, done0}, 8'd2);
    chk("tie_sum1", {2'b0, sum1}, 8'd30);
    step();
    req1 = 1'b0;
    chk("tie_idle", {7'b0, busy}, 8'd0);
    step();

    // Both held for 12 edges: expect completions 0,1,0,1.
    a0 = 6'd3;  b0 = 6'd4;
    a1 = 6'd20; b1 = 6'd50;
    exp_q.push_back({1'b0, 6'd7});
    exp_q.push_back({1'b1, 6'd6});
    exp_q.push_back({1'b0, 6'd7});
    exp_q.push_back({1'b1, 6'd6});
    req0 = 1'b1;
    req1 = 1'b1;
    repeat (12) step();
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) step();
    chk("fair_drained", exp_q.size()[7:0], 8'd0);
    chk("fair_idle", {7'b0, busy}, 8'd0);

    // Reset while in GRANT drops the operation.
    req0 = 1'b1; a0 = 6'd2; b0 = 6'd3;
    step();
    chk("mid_busy", {7'b0, busy}, 8'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {3'b0, gnt0, gnt1, done0, done1, busy}, 8'd0);
    chk("mid_rst_sum0", {2'b0, sum0}, 8'd0);
    chk("mid_rst_sum1", {2'b0, sum1}, 8'd0);
    step();
    step();
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 6'd5});
    step();
    chk("post_rst_gnt", {6'b0, gnt1, gnt0}, 8'd1);
    step();
    chk("post_rst_done", {6'b0, done1, done0}, 8'd1);
    chk("post_rst_sum0", {2'b0, sum0}, 8'd5);
    step();
    req0 = 1'b0;
    repeat (3) step();
    chk("final_drained", exp_q.size()[7:0], 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
